// File: rtl/traffic_light_controller.sv
// Two-way intersection lamp sequencer: NS green -> NS yellow -> EW green -> EW yellow,
// with a green phase repeating while only its own direction reports demand at phase end.
module traffic_light_controller #(
  parameter int NS_GREEN_TICKS = 32,
  parameter int EW_GREEN_TICKS = 16,
  parameter int YELLOW_TICKS   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic NS_VEHICLE_DETECT,
  input  logic EW_VEHICLE_DETECT,
  output logic NS_RED,
  output logic NS_YELLOW,
  output logic NS_GREEN,
  output logic EW_RED,
  output logic EW_YELLOW,
  output logic EW_GREEN
);

  localparam int NS_W = (NS_GREEN_TICKS > 1) ? $clog2(NS_GREEN_TICKS) : 1;
  localparam int EW_W = (EW_GREEN_TICKS > 1) ? $clog2(EW_GREEN_TICKS) : 1;
  localparam int Y_W  = (YELLOW_TICKS   > 1) ? $clog2(YELLOW_TICKS)   : 1;

  localparam logic [NS_W-1:0] NS_LAST = NS_W'(NS_GREEN_TICKS - 1);
  localparam logic [EW_W-1:0] EW_LAST = EW_W'(EW_GREEN_TICKS - 1);
  localparam logic [Y_W-1:0]  Y_LAST  = Y_W'(YELLOW_TICKS - 1);

  typedef enum logic [1:0] {
    S_NS_GREEN  = 2'd0,
    S_NS_YELLOW = 2'd1,
    S_EW_GREEN  = 2'd2,
    S_EW_YELLOW = 2'd3
  } state_t;

  // Lamp order: {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN}
  localparam logic [5:0] LAMPS_NS_GREEN  = 6'b001_100;
  localparam logic [5:0] LAMPS_NS_YELLOW = 6'b010_100;
  localparam logic [5:0] LAMPS_EW_GREEN  = 6'b100_001;
  localparam logic [5:0] LAMPS_EW_YELLOW = 6'b100_010;

  function automatic logic [5:0] lamps_for(input state_t s);
    logic [5:0] l;
    case (s)
      S_NS_GREEN:  l = LAMPS_NS_GREEN;
      S_NS_YELLOW: l = LAMPS_NS_YELLOW;
      S_EW_GREEN:  l = LAMPS_EW_GREEN;
      S_EW_YELLOW: l = LAMPS_EW_YELLOW;
      default:     l = LAMPS_NS_GREEN;
    endcase
    return l;
  endfunction

  state_t          state_r, next_state_s;
  logic [NS_W-1:0] ns_cnt_r, ns_cnt_next_s;
  logic [EW_W-1:0] ew_cnt_r, ew_cnt_next_s;
  logic [Y_W-1:0]  y_cnt_r,  y_cnt_next_s;
  logic [5:0]      lamps_r;

  // Next state and phase timers; idle timers are held at zero.
  always_comb begin
    next_state_s  = state_r;
    ns_cnt_next_s = '0;
    ew_cnt_next_s = '0;
    y_cnt_next_s  = '0;
    case (state_r)
      S_NS_GREEN: begin
        if (ns_cnt_r == NS_LAST) begin
          if (NS_VEHICLE_DETECT && !EW_VEHICLE_DETECT) begin
            next_state_s = S_NS_GREEN;
          end else begin
            next_state_s = S_NS_YELLOW;
          end
        end else begin
          ns_cnt_next_s = ns_cnt_r + NS_W'(1);
        end
      end
      S_NS_YELLOW: begin
        if (y_cnt_r == Y_LAST) begin
          next_state_s = S_EW_GREEN;
        end else begin
          y_cnt_next_s = y_cnt_r + Y_W'(1);
        end
      end
      S_EW_GREEN: begin
        if (ew_cnt_r == EW_LAST) begin
          if (EW_VEHICLE_DETECT && !NS_VEHICLE_DETECT) begin
            next_state_s = S_EW_GREEN;
          end else begin
            next_state_s = S_EW_YELLOW;
          end
        end else begin
          ew_cnt_next_s = ew_cnt_r + EW_W'(1);
        end
      end
      S_EW_YELLOW: begin
        if (y_cnt_r == Y_LAST) begin
          next_state_s = S_NS_GREEN;
        end else begin
          y_cnt_next_s = y_cnt_r + Y_W'(1);
        end
      end
      default: begin
        next_state_s = S_NS_GREEN;
      end
    endcase
  end

  // State, timers and lamps; lamps are registered from the next state so they track state_r exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_NS_GREEN;
      ns_cnt_r <= '0;
      ew_cnt_r <= '0;
      y_cnt_r  <= '0;
      lamps_r  <= LAMPS_NS_GREEN;
    end else begin
      state_r  <= next_state_s;
      ns_cnt_r <= ns_cnt_next_s;
      ew_cnt_r <= ew_cnt_next_s;
      y_cnt_r  <= y_cnt_next_s;
      lamps_r  <= lamps_for(next_state_s);
    end
  end

  assign {NS_RED, NS_YELLOW, NS_GREEN, EW_RED, EW_YELLOW, EW_GREEN} = lamps_r;

endmodule

// File: tb/tb_traffic_light_controller.sv
// Directed bench for traffic_light_controller: a table of {detects, edges to advance, expected lamps}
// applied from reset release, plus hand-written asynchronous-reset sequences and a per-cycle lamp invariant.
module tb_traffic_light_controller;

  localparam logic [5:0] NSG = 6'b001_100;
  localparam logic [5:0] NSY = 6'b010_100;
  localparam logic [5:0] EWG = 6'b100_001;
  localparam logic [5:0] EWY = 6'b100_010;

  typedef struct {
    logic       ns_det;
    logic       ew_det;
    int         adv;
    logic       every;
    logic [5:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  logic ns_det;
  logic ew_det;
  logic ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green;
  logic [5:0] lamps;
  logic inv_en;
  int checks;
  int failures;
  vec_t vq[$];

  traffic_light_controller dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .NS_VEHICLE_DETECT (ns_det),
    .EW_VEHICLE_DETECT (ew_det),
    .NS_RED            (ns_red),
    .NS_YELLOW         (ns_yellow),
    .NS_GREEN          (ns_green),
    .EW_RED            (ew_red),
    .EW_YELLOW         (ew_yellow),
    .EW_GREEN          (ew_green)
  );

  assign lamps = {ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [5:0] exp);
    checks++;
    if (lamps !== exp) begin
      failures++;
      $display("FAIL %s: lamps got=%b expected=%b at %0t", name, lamps, exp, $time);
    end
  endtask

  // One lamp per direction, and at least one direction red, on every cycle.
  always @(negedge clk) begin
    if (inv_en) begin
      checks++;
      if (!($countones({ns_red, ns_yellow, ns_green}) == 1 &&
            $countones({ew_red, ew_yellow, ew_green}) == 1 &&
            (ns_red || ew_red))) begin
        failures++;
        $display("FAIL invariant: lamps got=%b expected one-hot per direction with a red side at %0t",
                 lamps, $time);
      end
    end
  end

  initial begin
    checks   = 0;
    failures = 0;
    inv_en   = 1'b0;
    rst_n    = 1'b0;
    ns_det   = 1'b0;
    ew_det   = 1'b0;

    // Edge numbers in comments are counted from reset release.
    vq.push_back('{1'b0, 1'b0, 31, 1'b0, NSG});  // 31
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, NSY});  // 32
    vq.push_back('{1'b0, 1'b0,  3, 1'b0, NSY});  // 35
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, EWG});  // 36
    vq.push_back('{1'b0, 1'b0, 15, 1'b0, EWG});  // 51
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, EWY});  // 52
    vq.push_back('{1'b0, 1'b0,  3, 1'b0, EWY});  // 55
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, NSG});  // 56
    vq.push_back('{1'b0, 1'b0, 31, 1'b0, NSG});  // 87
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, NSY});  // 88
    // both detects: fixed cycle, yellow not extended
    vq.push_back('{1'b1, 1'b1,  4, 1'b0, EWG});  // 92
    vq.push_back('{1'b1, 1'b1, 15, 1'b0, EWG});  // 107
    vq.push_back('{1'b1, 1'b1,  1, 1'b0, EWY});  // 108
    vq.push_back('{1'b1, 1'b1,  4, 1'b0, NSG});  // 112
    vq.push_back('{1'b1, 1'b1, 31, 1'b0, NSG});  // 143
    vq.push_back('{1'b1, 1'b1,  1, 1'b0, NSY});  // 144
    // EW extension, then release at a boundary
    vq.push_back('{1'b0, 1'b0,  4, 1'b0, EWG});  // 148
    vq.push_back('{1'b0, 1'b1, 16, 1'b1, EWG});  // 164 (extended)
    vq.push_back('{1'b0, 1'b1, 16, 1'b1, EWG});  // 180 (extended)
    vq.push_back('{1'b0, 1'b0, 15, 1'b1, EWG});  // 195
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, EWY});  // 196
    vq.push_back('{1'b0, 1'b0,  3, 1'b1, EWY});  // 199
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, NSG});  // 200
    // NS extension for 200 edges
    vq.push_back('{1'b1, 1'b0, 50, 1'b1, NSG});  // 250
    vq.push_back('{1'b1, 1'b0, 50, 1'b1, NSG});  // 300
    vq.push_back('{1'b1, 1'b0, 50, 1'b1, NSG});  // 350
    vq.push_back('{1'b1, 1'b0, 50, 1'b1, NSG});  // 400, timer at 8
    vq.push_back('{1'b0, 1'b0, 23, 1'b1, NSG});  // 423
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, NSY});  // 424
    // detect pulses away from phase ends are ignored
    vq.push_back('{1'b0, 1'b0,  4, 1'b0, EWG});  // 428
    vq.push_back('{1'b1, 1'b0,  5, 1'b1, EWG});  // 433
    vq.push_back('{1'b0, 1'b1,  1, 1'b0, EWG});  // 434
    vq.push_back('{1'b0, 1'b0,  9, 1'b1, EWG});  // 443
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, EWY});  // 444
    vq.push_back('{1'b0, 1'b0,  4, 1'b0, NSG});  // 448
    vq.push_back('{1'b1, 1'b0, 10, 1'b1, NSG});  // 458
    vq.push_back('{1'b0, 1'b0, 21, 1'b1, NSG});  // 479
    vq.push_back('{1'b0, 1'b0,  1, 1'b0, NSY});  // 480

    repeat (2) @(posedge clk);
    #1;
    check("reset_state", NSG);
    inv_en = 1'b1;
    rst_n  = 1'b1;

    for (int i = 0; i < vq.size(); i++) begin
      ns_det = vq[i].ns_det;
      ew_det = vq[i].ew_det;
      for (int e = 0; e < vq[i].adv; e++) begin
        @(posedge clk);
        #1;
        if (vq[i].every) check($sformatf("vec%0d_edge%0d", i, e + 1), vq[i].exp);
      end
      if (!vq[i].every) check($sformatf("vec%0d", i), vq[i].exp);
    end

    // Asynchronous reset during NS yellow, then a second one at edge 40 in EW green.
    ns_det = 1'b0;
    ew_det = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("async_reset_from_yellow", NSG);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (39) @(posedge clk);
    #1 check("rerun_edge39", EWG);
    @(posedge clk);
    #1 check("rerun_edge40", EWG);
    #1 rst_n = 1'b0;
    #1 check("async_reset_mid_ew_green", NSG);
    repeat (2) @(posedge clk);
    #1 check("reset_held", NSG);
    rst_n = 1'b1;
    repeat (31) @(posedge clk);
    #1 check("post_reset_edge31", NSG);
    @(posedge clk);
    #1 check("post_reset_edge32", NSY);
    repeat (4) @(posedge clk);
    #1 check("post_reset_edge36", EWG);

    inv_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_light_controller.md
# traffic_light_controller

Two-way intersection signal controller: a Moore state machine sequencing north-south (NS) and east-west (EW) red/yellow/green lamps, with internal phase timers for NS green, EW green and yellow. One clock cycle is one timing tick (one "second"). Vehicle-detect inputs extend a green phase when only that direction has demand. The block sits between the roadside sensor inputs and the lamp drivers.

## Interface
- NS_GREEN_TICKS, 32, NS green phase length in ticks (NS timer is 5 bits).
- EW_GREEN_TICKS, 16, EW green phase length in ticks (EW timer is 4 bits).
- YELLOW_TICKS, 4, yellow phase length in ticks, either direction (yellow timer is 2 bits).
- One clock; reset is asynchronous and active-low.
- clk  input  1  clock; one rising edge = one tick.
- rst_n  input  1  asynchronous active-low reset.
- NS_VEHICLE_DETECT  input  1  vehicle waiting/present on NS approach; synchronous, sampled on clk.
- EW_VEHICLE_DETECT  input  1  vehicle waiting/present on EW approach; synchronous, sampled on clk.
- NS_RED, NS_YELLOW, NS_GREEN  output  1 each  NS lamps, one-hot.
- EW_RED, EW_YELLOW, EW_GREEN  output  1 each  EW lamps, one-hot.

## Operation
- States: S_NS_GREEN, S_NS_YELLOW, S_EW_GREEN, S_EW_YELLOW. Outputs decode only from the registered state (Moore).
  - S_NS_GREEN: NS_GREEN=1, EW_RED=1.
  - S_NS_YELLOW: NS_YELLOW=1, EW_RED=1.
  - S_EW_GREEN: NS_RED=1, EW_GREEN=1.
  - S_EW_YELLOW: NS_RED=1, EW_YELLOW=1.
  - All other lamp outputs 0. Each direction has exactly one lamp on at all times. Both directions are never simultaneously non-red.
- Timers: nsCounter (5-bit), ewCounter (4-bit) and yellowCounter (2-bit). Only the timer for the current state counts; it increments by 1 per tick starting from 0. The other timers are held at 0.
- Phase end occurs when the active timer equals its length-1 (31, 15 or 3). On that edge the active timer clears to 0 and the next state is taken:
  - S_NS_GREEN end: if NS_VEHICLE_DETECT=1 and EW_VEHICLE_DETECT=0, stay in S_NS_GREEN for a fresh 32-tick period. Otherwise go to S_NS_YELLOW.
  - S_NS_YELLOW end: go to S_EW_GREEN.
  - S_EW_GREEN end: if EW_VEHICLE_DETECT=1 and NS_VEHICLE_DETECT=0, stay in S_EW_GREEN for a fresh 16-tick period. Otherwise go to S_EW_YELLOW.
  - S_EW_YELLOW end: go to S_NS_GREEN.
- Detect inputs are evaluated only on the phase-end edge. Values at other times have no effect. Yellow phases are never extended.
- Extensions are unlimited: a green repeats as long as the condition holds at each phase end.
- With both detects equal (0/0 or 1/1), the controller runs the fixed cycle: 32 + 4 + 16 + 4 = 56 ticks.

## Timing
- Reset (rst_n=0, asynchronous): state=S_NS_GREEN and all timers=0, immediately and without waiting for clk. Outputs: NS_GREEN=1, EW_RED=1, all other lamps 0.
- Reset asserted mid-phase returns immediately to the reset state. The NS green phase restarts at a full 32 ticks after release.
- Count tick k = rising edges since reset release (first edge is k=1), with both detects 0:
  - NS green holds through edge 31.
  - NS yellow starts at edge 32.
  - EW green starts at edge 36.
  - EW yellow starts at edge 52.
  - NS green starts at edge 56.
  - The pattern then repeats every 56 edges.
- Lamp outputs change only on a clk rising edge (or on asynchronous reset). There are no combinational paths from the detect inputs to the outputs.
- Timer wrap: the phase-end clear happens at length-1, so no timer ever overflows naturally.

## Test plan
- Reset check: rst_n=0 -> NS_GREEN=1, EW_RED=1, others 0. Release with detects 0/0 -> after 32 edges NS_YELLOW=1, after 36 EW_GREEN=1, after 52 EW_YELLOW=1, after 56 NS_GREEN=1.
- NS extension: NS_VEHICLE_DETECT=1, EW=0 held -> NS_GREEN stays 1 for 200 edges, and EW_RED stays 1 throughout.
- EW extension: free-run into S_EW_GREEN, then set EW_VEHICLE_DETECT=1, NS=0 -> EW_GREEN persists past 16 ticks. Clear EW detect -> EW_YELLOW starts at the next 16-tick phase boundary, lasting 4 ticks.
- Conflicting demand: both detects=1 -> same 56-tick cycle as 0/0. A detect pulse that does not coincide with a phase end has no effect.
- Mid-phase reset: assert rst_n=0 at edge 40 (EW green) -> outputs go to NS_GREEN/EW_RED immediately. After release, NS yellow starts 32 edges later.
- Invariant checks every cycle: exactly one lamp on per direction, and never both directions green/yellow at once.
